// File: rtl/linebuf_dbl.sv
// -----------------------------------------------------------------------------
// linebuf_dbl
//
// Double-buffered scanline buffer sitting in front of the palette lookup.
// The renderer writes 9-bit colour indices at arbitrary x positions into the
// render bank. At the same time the display side streams the other bank out at
// pixel rate. The two banks swap roles on every line_start. Each displayed pixel
// is overwritten with CLEAR_COLOUR in the same cycle it is read, so a bank is
// blank again by the time the renderer receives it back. After reset, an init
// sweep clears both banks before the block accepts any traffic.
//
// Parameters
//   H_ACTIVE      active pixels per line (depth of each bank)
//   X_W           x coordinate width, 2**X_W >= H_ACTIVE
//   CLEAR_COLOUR  background index written on clear / shown when no pixel
//
// Ports
//   clk_pix       in   pixel clock, all logic on the rising edge
//   rst_n         in   asynchronous active-low reset
//   line_start    in   one-cycle pulse: swap banks, restart display read
//   disp_en       in   read the next display pixel this cycle
//   colour_pix    out  palette index, one cycle after disp_en
//   colour_valid  out  colour_pix carries a read result
//   wr_valid      in   renderer write request
//   wr_ready      out  write accepted when wr_valid & wr_ready
//   wr_x          in   write x position
//   wr_colour     in   write colour index (low nibble 0 = transparent)
//   init_done     out  init sweep finished
//   overrun       out  sticky: disp_en seen past the end of the line
// -----------------------------------------------------------------------------
module linebuf_dbl #(
    parameter int         H_ACTIVE     = 640,
    parameter int         X_W          = 10,
    parameter logic [8:0] CLEAR_COLOUR = 9'h000
) (
    input  logic           clk_pix,
    input  logic           rst_n,
    input  logic           line_start,
    input  logic           disp_en,
    output logic [8:0]     colour_pix,
    output logic           colour_valid,
    input  logic           wr_valid,
    output logic           wr_ready,
    input  logic [X_W-1:0] wr_x,
    input  logic [8:0]     wr_colour,
    output logic           init_done,
    output logic           overrun
);

    // The read pointer needs one extra bit so that it can rest at H_ACTIVE
    // even when H_ACTIVE == 2**X_W.
    localparam int                RD_W    = X_W + 1;
    localparam logic [X_W-1:0]    IC_LAST = X_W'(H_ACTIVE - 1);
    localparam logic [RD_W-1:0]   RD_END  = RD_W'(H_ACTIVE);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [X_W-1:0]  ic_q, ic_d;
    logic [RD_W-1:0] rd_x_q, rd_x_d;
    logic            disp_sel_q, disp_sel_d;
    logic            overrun_q, overrun_d;
    logic            rd_valid_q, rd_valid_d;
    logic            rd_hit_q, rd_hit_d;
    logic            rd_bank_q, rd_bank_d;

    logic            run;
    logic            disp_req;
    logic            rd_in_range;
    logic            rd_fire;
    logic            wr_store;
    logic [8:0]      bank_rdata [2];

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. INIT runs until the last address has been cleared.
    // RUN is left only through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (ic_q == IC_LAST) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // FSM: outputs. Both outputs come straight from the state register.
    always_comb begin
        run       = (state_q == ST_RUN);
        wr_ready  = run;
        init_done = run;
    end

    // -------------------------------------------------------------------------
    // Datapath control
    // -------------------------------------------------------------------------
    always_comb begin
        // When a display request arrives in the same cycle as line_start, the
        // request is ignored. The swap takes priority.
        disp_req    = run & disp_en & ~line_start;
        rd_in_range = (rd_x_q < RD_END);
        rd_fire     = disp_req & rd_in_range;
        // Out-of-range and transparent writes are still accepted. They are not
        // stored.
        wr_store    = run & wr_valid
                    & ({1'b0, wr_x} < RD_END)
                    & (wr_colour[3:0] != 4'h0);
    end

    always_comb begin
        ic_d       = ic_q;
        rd_x_d     = rd_x_q;
        disp_sel_d = disp_sel_q;

        if (state_q == ST_INIT) begin
            ic_d = ic_q + X_W'(1);
        end

        if (run && line_start) begin
            disp_sel_d = ~disp_sel_q;
            rd_x_d     = '0;
        end else if (rd_fire) begin
            rd_x_d     = rd_x_q + RD_W'(1);
        end

        overrun_d  = overrun_q | (disp_req & ~rd_in_range);
        rd_valid_d = disp_req;
        rd_hit_d   = rd_fire;
        rd_bank_d  = disp_sel_q;
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            ic_q       <= '0;
            rd_x_q     <= '0;
            disp_sel_q <= 1'b0;
            overrun_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
            rd_bank_q  <= 1'b0;
        end else begin
            ic_q       <= ic_d;
            rd_x_q     <= rd_x_d;
            disp_sel_q <= disp_sel_d;
            overrun_q  <= overrun_d;
            rd_valid_q <= rd_valid_d;
            rd_hit_q   <= rd_hit_d;
            rd_bank_q  <= rd_bank_d;
        end
    end

    // -------------------------------------------------------------------------
    // Banks: one write port and one registered read port each.
    //   INIT              : both banks are cleared at address ic.
    //   RUN, display bank : clear-on-read at rd_x (the read returns old data).
    //   RUN, render bank  : renderer writes.
    // During RUN a bank is never both display bank and render bank. Each bank
    // therefore sees at most one write per cycle.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        localparam logic BANK_ID = 1'(gi);

        logic [8:0]     mem [H_ACTIVE];
        logic [8:0]     rdata_q;
        logic           we;
        logic [X_W-1:0] waddr;
        logic [8:0]     wdata;
        logic           re;

        always_comb begin
            we    = 1'b0;
            waddr = ic_q;
            wdata = CLEAR_COLOUR;
            if (!run) begin
                we = 1'b1;
            end else if (disp_sel_q == BANK_ID) begin
                we    = rd_fire;
                waddr = rd_x_q[X_W-1:0];
            end else begin
                we    = wr_store;
                waddr = wr_x;
                wdata = wr_colour;
            end
        end

        assign re = rd_fire & (disp_sel_q == BANK_ID);

        always_ff @(posedge clk_pix) begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            if (re) begin
                rdata_q <= mem[rd_x_q[X_W-1:0]];
            end
        end

        assign bank_rdata[gi] = rdata_q;
    end

    // -------------------------------------------------------------------------
    // Outputs. colour_pix shows CLEAR_COLOUR whenever no bank read took place
    // in the previous cycle. This covers the overrun case, which asserts
    // colour_valid without accessing a bank.
    // -------------------------------------------------------------------------
    assign colour_valid = rd_valid_q;
    assign colour_pix   = rd_hit_q ? bank_rdata[rd_bank_q] : CLEAR_COLOUR;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_linebuf_dbl.sv
// -----------------------------------------------------------------------------
// tb_linebuf_dbl
//
// Directed bench for linebuf_dbl. Each display read pushes its hand-written
// expected colour, together with the cycle in which it must appear, into a
// scoreboard queue. A monitor on the falling edge pops an entry whenever
// colour_valid is high. It also flags outputs that are missing, late or
// unexpected.
// -----------------------------------------------------------------------------
module tb_linebuf_dbl;

    localparam int H   = 640;
    localparam int X_W = 10;

    logic           clk_pix = 1'b0;
    logic           rst_n;
    logic           line_start;
    logic           disp_en;
    logic [8:0]     colour_pix;
    logic           colour_valid;
    logic           wr_valid;
    logic           wr_ready;
    logic [X_W-1:0] wr_x;
    logic [8:0]     wr_colour;
    logic           init_done;
    logic           overrun;

    linebuf_dbl #(
        .H_ACTIVE    (H),
        .X_W         (X_W),
        .CLEAR_COLOUR(9'h000)
    ) dut (
        .clk_pix     (clk_pix),
        .rst_n       (rst_n),
        .line_start  (line_start),
        .disp_en     (disp_en),
        .colour_pix  (colour_pix),
        .colour_valid(colour_valid),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_x        (wr_x),
        .wr_colour   (wr_colour),
        .init_done   (init_done),
        .overrun     (overrun)
    );

    always #5 clk_pix = ~clk_pix;

    int cyc = 0;
    always @(posedge clk_pix) cyc <= cyc + 1;

    typedef struct {
        logic [8:0] col;
        int         cyc;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_line [0:H];

    // Monitor: compares every presented output against the scoreboard.
    always @(negedge clk_pix) begin
        exp_t e;
        if (colour_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: colour_valid=1 colour_pix=%h at cycle %0d, expected no output",
                         colour_pix, cyc);
            end else begin
                e = sb_q.pop_front();
                if (colour_pix !== e.col || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL pixel: got %h at cycle %0d, expected %h at cycle %0d",
                             colour_pix, cyc, e.col, e.cyc);
                end
            end
        end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            checks++;
            errors++;
            e = sb_q.pop_front();
            $display("FAIL missing_valid: no output at cycle %0d, expected %h", cyc, e.col);
        end
    end

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i <= H; i++) exp_line[i] = 9'h000;
    endtask

    task automatic wr(input int x, input logic [8:0] c);
        wr_valid  = 1'b1;
        wr_x      = X_W'(x);
        wr_colour = c;
        chk("wr_ready", 32'(wr_ready), 32'd1);
        $display("write x=%0d colour=%h", x, c);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_line_start();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            disp_en = 1'b1;
            sb_q.push_back('{col: exp_line[i], cyc: cyc + 1});
            tick();
        end
        disp_en = 1'b0;
        tick();
        tick();
        $display("streamed %0d pixels", n);
    endtask

    // Releases reset and counts the INIT cycles. line_start and disp_en are
    // toggled during the sweep. Both must be ignored.
    task automatic release_and_init();
        int n;
        n = 0;
        rst_n = 1'b1;
        while (!wr_ready && n < 2000) begin
            disp_en    = 1'b1;
            line_start = (n % 7 == 0);
            chk("init_done_low", 32'(init_done), 32'd0);
            tick();
            n++;
        end
        disp_en    = 1'b0;
        line_start = 1'b0;
        chk("init_len", 32'(n), 32'd640);
        chk("init_done", 32'(init_done), 32'd1);
        chk("wr_ready_run", 32'(wr_ready), 32'd1);
        $display("init sweep took %0d cycles", n);
    endtask

    task automatic check_reset_state();
        chk("rst_colour_valid", 32'(colour_valid), 32'd0);
        chk("rst_colour_pix", 32'(colour_pix), 32'h000);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        line_start = 1'b0;
        disp_en    = 1'b0;
        wr_valid   = 1'b0;
        wr_x       = '0;
        wr_colour  = 9'h000;
        tick();
        tick();
        tick();
        check_reset_state();
        release_and_init();

        // Blank line straight after init.
        clear_exp();
        pulse_line_start();
        stream(H);

        // Writes at both ends of the line.
        wr(0, 9'h1A5);
        wr(639, 9'h0F3);
        pulse_line_start();
        clear_exp();
        exp_line[0]   = 9'h1A5;
        exp_line[639] = 9'h0F3;
        stream(H);

        // The same bank comes back after two swaps and must be blank.
        pulse_line_start();
        pulse_line_start();
        clear_exp();
        stream(H);

        // A transparent write, an out-of-range write, and an overwrite.
        wr(5, 9'h120);
        wr(700, 9'h033);
        wr(6, 9'h011);
        wr(6, 9'h022);
        pulse_line_start();
        clear_exp();
        exp_line[6] = 9'h022;
        stream(H);
        chk("overrun_before", 32'(overrun), 32'd0);

        // Overrun: the 641st read shows background and sets the sticky flag.
        pulse_line_start();
        clear_exp();
        stream(H + 1);
        chk("overrun_set", 32'(overrun), 32'd1);
        pulse_line_start();
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // line_start coincides with disp_en and a write.
        line_start = 1'b1;
        disp_en    = 1'b1;
        wr_valid   = 1'b1;
        wr_x       = X_W'(3);
        wr_colour  = 9'h044;
        $display("write x=3 colour=044 with line_start and disp_en");
        tick();
        line_start = 1'b0;
        disp_en    = 1'b0;
        wr_valid   = 1'b0;
        chk("ls_no_valid", 32'(colour_valid), 32'd0);
        clear_exp();
        exp_line[3] = 9'h044;
        stream(H);
        chk("overrun_still", 32'(overrun), 32'd1);

        // Leave data behind in both banks, then reset in the middle of a line.
        wr(200, 9'h155);
        pulse_line_start();
        clear_exp();
        stream(100);
        wr(30, 9'h066);
        rst_n = 1'b0;
        tick();
        tick();
        check_reset_state();
        release_and_init();
        clear_exp();
        pulse_line_start();
        stream(H);
        pulse_line_start();
        stream(H);
        chk("overrun_after_reset", 32'(overrun), 32'd0);

        tick();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/linebuf_dbl.md
# linebuf_dbl

Double-buffered scanline buffer feeding the palette lookup stage. The renderer side writes 9-bit colour indices at arbitrary x positions into one bank while the display side streams the other bank out at pixel rate as `colour_pix`; banks swap at each line start. Displayed pixels are cleared as they are read, so every line starts from a known background. A post-reset init sweep clears both banks before normal operation.

## Interface
- `H_ACTIVE`, 640: active pixels per line; bank depth.
- `X_W`, 10: width of x coordinates; must satisfy 2^X_W >= H_ACTIVE.
- `CLEAR_COLOUR`, 9'h000: background index written on clear and output when no valid pixel exists.

- `clk_pix`  in  1  pixel clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `line_start`  in  1  one-cycle pulse: swap banks, restart display read.
- `disp_en`  in  1  active-pixel strobe: read the next display pixel this cycle.
- `colour_pix`  out  9  palette index to palette stage, registered.
- `colour_valid`  out  1  `colour_pix` carries a read result.
- `wr_valid`  in  1  renderer write request.
- `wr_ready`  out  1  write accepted when `wr_valid & wr_ready`.
- `wr_x`  in  X_W  write x position.
- `wr_colour`  in  9  write colour index.
- `init_done`  out  1  init sweep complete.
- `overrun`  out  1  sticky: `disp_en` seen with read pointer at H_ACTIVE; cleared only by reset.

## Operation
- Storage: two banks of H_ACTIVE x 9 bits; `disp_sel` selects display bank, the other is render bank. Each bank has one read and one write port; read-first semantics on same-address read/write.
- FSM states INIT, RUN.
  - INIT (entered on reset): counter `ic` 0..H_ACTIVE-1 writes CLEAR_COLOUR to address `ic` of both banks each cycle; `wr_ready`=0; `line_start`/`disp_en` ignored; `colour_pix`=CLEAR_COLOUR, `colour_valid`=0. After `ic`=H_ACTIVE-1 written, go RUN, `init_done`=1.
  - RUN: stays until reset.
- Display path (RUN): `rd_x` counter. When `disp_en` and `rd_x` < H_ACTIVE: read display bank[`rd_x`], write CLEAR_COLOUR to same address same cycle (read returns old data), `rd_x`++. When `disp_en` and `rd_x` = H_ACTIVE: no access, output CLEAR_COLOUR, set `overrun`; `rd_x` saturates.
- Render path (RUN): `wr_ready`=1. Accepted write with `wr_x` < H_ACTIVE and `wr_colour[3:0]` != 0 stores `wr_colour` at render bank[`wr_x`]. `wr_colour[3:0]`=0 is transparent: accepted, not stored. `wr_x` >= H_ACTIVE: accepted, dropped. Later write to same x overwrites earlier.
- `line_start` (RUN): `disp_sel` toggles, `rd_x`<=0, effective next cycle. `disp_en` in the same cycle is ignored (no read, no `rd_x` change, `colour_valid`=0 next cycle). A write accepted in the `line_start` cycle lands in the pre-swap render bank (i.e. the bank about to be displayed).
- Reset mid-operation: immediate return to INIT; bank contents and in-flight writes discarded; full sweep repeats.

## Timing
- Reset values: `colour_pix`=CLEAR_COLOUR, `colour_valid`=0, `wr_ready`=0, `init_done`=0, `overrun`=0, `disp_sel`=0, `rd_x`=0, `ic`=0.
- Read latency 1: `disp_en` at cycle n with `rd_x`=k gives `colour_pix`=bank[k], `colour_valid`=1 at n+1. Cycles without a read: `colour_valid`=0, `colour_pix` = CLEAR_COLOUR.
- Write latency 1: accepted write at cycle n is visible to a display read at cycle >= n+1 after the banks swap.
- INIT lasts exactly H_ACTIVE cycles after reset release; `wr_ready` and `init_done` rise together in the first RUN cycle.
- Throughput: one read and one write per cycle, no stalls in RUN.

## Test plan
- Reset release -> `wr_ready`=0 for 640 cycles, then `init_done`=`wr_ready`=1; stream a line with no writes -> 640 outputs of 9'h000, `colour_valid` 1 cycle after each `disp_en`.
- Write x=0 colour 9'h1A5, x=639 colour 9'h0F3, `line_start`, stream 640 -> out[0]=9'h1A5, out[639]=9'h0F3, others 9'h000, first valid 1 cycle after first `disp_en`.
- Same line streamed again after two further `line_start` with no writes -> all 9'h000 (clear-on-read verified).
- Writes x=5 colour 9'h120 (transparent), x=700 colour 9'h033, x=6 colour 9'h011 then 9'h022 -> out[5]=9'h000, out[6]=9'h022, no out-of-range effect.
- 641 `disp_en` in one line -> 641st output 9'h000, `overrun`=1 and stays 1 across `line_start`; clears only on `rst_n`.
- `line_start` coinciding with `disp_en` and a write at x=3 colour 9'h044 -> no `colour_valid` next cycle, next line out[3]=9'h044; `rst_n` pulsed mid-line -> INIT repeats, subsequent line all 9'h000.
